// File: rtl/controlador_vga.sv
// VGA 640x480@60Hz timing generator with the fixed overlay "GRUPO 11" centred on screen.
// Optional macro TEXT_COLOR_SW_EN adds the sw[2:0] port that selects the text colour.
module controlador_vga #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SP   = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SP   = 2,
    parameter int V_BP   = 33,
    parameter int TXT_X0 = 256,
    parameter int TXT_Y0 = 224
) (
    input  logic       clk,
    input  logic       reset,
`ifdef TEXT_COLOR_SW_EN
    input  logic [2:0] sw,
`endif
    output logic [2:0] rgbtext,
    output logic       hsync,
    output logic       vsync
);

    localparam int H_TOT = H_VIS + H_FP + H_SP + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SP + V_BP;

    localparam logic [9:0] H_LAST     = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_END  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_END  = 10'(V_VIS);
    localparam logic [9:0] H_SYNC_BEG = 10'(H_VIS + H_FP);
    localparam logic [9:0] H_SYNC_LST = 10'(H_VIS + H_FP + H_SP - 1);
    localparam logic [9:0] V_SYNC_BEG = 10'(V_VIS + V_FP);
    localparam logic [9:0] V_SYNC_LST = 10'(V_VIS + V_FP + V_SP - 1);
    // 8 characters of 16x32 pixels (8x16 font doubled in both directions)
    localparam logic [9:0] TXT_X_BEG  = 10'(TXT_X0);
    localparam logic [9:0] TXT_X_END  = 10'(TXT_X0 + 128);
    localparam logic [9:0] TXT_Y_BEG  = 10'(TXT_Y0);
    localparam logic [9:0] TXT_Y_END  = 10'(TXT_Y0 + 32);

    typedef enum logic [2:0] {
        GL_SPACE,
        GL_G,
        GL_R,
        GL_U,
        GL_P,
        GL_O,
        GL_1
    } glyph_e;

    logic       tick_q,  tick_d;
    logic [9:0] h_cnt_q, h_cnt_d;
    logic [9:0] v_cnt_q, v_cnt_d;
    logic       hsync_q, hsync_d;
    logic       vsync_q, vsync_d;
    logic [2:0] rgb_q,   rgb_d;

    logic [2:0] text_color;
    logic       video_on;
    logic       in_text;
    logic [5:0] h_half;
    logic [2:0] char_idx;
    logic [2:0] glyph_col;
    logic [3:0] glyph_row;
    glyph_e     glyph;
    logic [7:0] row_bits;
    logic       pix_on;

`ifdef TEXT_COLOR_SW_EN
    assign text_color = sw;
`else
    assign text_color = 3'b111;
`endif

    function automatic glyph_e char_glyph(input logic [2:0] idx);
        case (idx)
            3'd0:    char_glyph = GL_G;
            3'd1:    char_glyph = GL_R;
            3'd2:    char_glyph = GL_U;
            3'd3:    char_glyph = GL_P;
            3'd4:    char_glyph = GL_O;
            3'd5:    char_glyph = GL_SPACE;
            default: char_glyph = GL_1;
        endcase
    endfunction

    // Rows not listed (including the whole space glyph) are blank.
    function automatic logic [7:0] font_row(input glyph_e g, input logic [3:0] row);
        case ({g, row})
            {GL_G, 4'd2}:  font_row = 8'h3C;
            {GL_G, 4'd3}:  font_row = 8'h66;
            {GL_G, 4'd4}:  font_row = 8'hC2;
            {GL_G, 4'd5}:  font_row = 8'hC0;
            {GL_G, 4'd6}:  font_row = 8'hC0;
            {GL_G, 4'd7}:  font_row = 8'hDE;
            {GL_G, 4'd8}:  font_row = 8'hC6;
            {GL_G, 4'd9}:  font_row = 8'hC6;
            {GL_G, 4'd10}: font_row = 8'h66;
            {GL_G, 4'd11}: font_row = 8'h3A;
            {GL_R, 4'd2}:  font_row = 8'hFC;
            {GL_R, 4'd3}:  font_row = 8'h66;
            {GL_R, 4'd4}:  font_row = 8'h66;
            {GL_R, 4'd5}:  font_row = 8'h66;
            {GL_R, 4'd6}:  font_row = 8'h7C;
            {GL_R, 4'd7}:  font_row = 8'h6C;
            {GL_R, 4'd8}:  font_row = 8'h66;
            {GL_R, 4'd9}:  font_row = 8'h66;
            {GL_R, 4'd10}: font_row = 8'h66;
            {GL_R, 4'd11}: font_row = 8'hE6;
            {GL_U, 4'd2}:  font_row = 8'hC6;
            {GL_U, 4'd3}:  font_row = 8'hC6;
            {GL_U, 4'd4}:  font_row = 8'hC6;
            {GL_U, 4'd5}:  font_row = 8'hC6;
            {GL_U, 4'd6}:  font_row = 8'hC6;
            {GL_U, 4'd7}:  font_row = 8'hC6;
            {GL_U, 4'd8}:  font_row = 8'hC6;
            {GL_U, 4'd9}:  font_row = 8'hC6;
            {GL_U, 4'd10}: font_row = 8'hC6;
            {GL_U, 4'd11}: font_row = 8'h7C;
            {GL_P, 4'd2}:  font_row = 8'hFC;
            {GL_P, 4'd3}:  font_row = 8'h66;
            {GL_P, 4'd4}:  font_row = 8'h66;
            {GL_P, 4'd5}:  font_row = 8'h66;
            {GL_P, 4'd6}:  font_row = 8'h7C;
            {GL_P, 4'd7}:  font_row = 8'h60;
            {GL_P, 4'd8}:  font_row = 8'h60;
            {GL_P, 4'd9}:  font_row = 8'h60;
            {GL_P, 4'd10}: font_row = 8'h60;
            {GL_P, 4'd11}: font_row = 8'hF0;
            {GL_O, 4'd2}:  font_row = 8'h7C;
            {GL_O, 4'd3}:  font_row = 8'hC6;
            {GL_O, 4'd4}:  font_row = 8'hC6;
            {GL_O, 4'd5}:  font_row = 8'hC6;
            {GL_O, 4'd6}:  font_row = 8'hC6;
            {GL_O, 4'd7}:  font_row = 8'hC6;
            {GL_O, 4'd8}:  font_row = 8'hC6;
            {GL_O, 4'd9}:  font_row = 8'hC6;
            {GL_O, 4'd10}: font_row = 8'hC6;
            {GL_O, 4'd11}: font_row = 8'h7C;
            {GL_1, 4'd2}:  font_row = 8'h18;
            {GL_1, 4'd3}:  font_row = 8'h38;
            {GL_1, 4'd4}:  font_row = 8'h78;
            {GL_1, 4'd5}:  font_row = 8'h18;
            {GL_1, 4'd6}:  font_row = 8'h18;
            {GL_1, 4'd7}:  font_row = 8'h18;
            {GL_1, 4'd8}:  font_row = 8'h18;
            {GL_1, 4'd9}:  font_row = 8'h18;
            {GL_1, 4'd10}: font_row = 8'h18;
            {GL_1, 4'd11}: font_row = 8'h7E;
            default:       font_row = 8'h00;
        endcase
    endfunction

    // Pixel counters advance on every other clk, giving the 25 MHz pixel rate.
    always_comb begin
        tick_d  = ~tick_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (tick_q) begin
            if (h_cnt_q == H_LAST) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
            end else begin
                h_cnt_d = h_cnt_q + 10'd1;
            end
        end
    end

    always_comb begin
        video_on  = (h_cnt_q < H_VIS_END) && (v_cnt_q < V_VIS_END);
        in_text   = (h_cnt_q >= TXT_X_BEG) && (h_cnt_q < TXT_X_END) &&
                    (v_cnt_q >= TXT_Y_BEG) && (v_cnt_q < TXT_Y_END);
        h_half    = 6'((h_cnt_q - TXT_X_BEG) >> 1);
        char_idx  = h_half[5:3];
        glyph_col = h_half[2:0];
        glyph_row = 4'((v_cnt_q - TXT_Y_BEG) >> 1);
        glyph     = char_glyph(char_idx);
        row_bits  = font_row(glyph, glyph_row);
        // bit 7 is the leftmost pixel of a glyph row
        pix_on    = row_bits[3'd7 - glyph_col];

        rgb_d   = (video_on && in_text && pix_on) ? text_color : 3'b000;
        hsync_d = !((h_cnt_q >= H_SYNC_BEG) && (h_cnt_q <= H_SYNC_LST));
        vsync_d = !((v_cnt_q >= V_SYNC_BEG) && (v_cnt_q <= V_SYNC_LST));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tick_q  <= 1'b0;
            h_cnt_q <= '0;
            v_cnt_q <= '0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            rgb_q   <= 3'b000;
        end else begin
            tick_q  <= tick_d;
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign rgbtext = rgb_q;
    assign hsync   = hsync_q;
    assign vsync   = vsync_q;

endmodule

// File: tb/tb_controlador_vga.sv
// Bench for controlador_vga: a full-size instance for line timing and a shrunken-geometry
// instance so whole frames (text and vsync) fit in a short run. Honours TEXT_COLOR_SW_EN.
`timescale 1ns/1ps
module tb_controlador_vga;

    typedef struct packed {
        int hv; int hf; int hs; int hb;
        int vv; int vf; int vs; int vb;
        int tx; int ty;
    } geom_t;

    localparam geom_t G_DEF = '{hv: 640, hf: 16, hs: 96, hb: 48,
                                vv: 480, vf: 10, vs: 2,  vb: 33,
                                tx: 256, ty: 224};
    localparam geom_t G_SCL = '{hv: 160, hf: 4,  hs: 8,  hb: 4,
                                vv: 40,  vf: 2,  vs: 2,  vb: 2,
                                tx: 16,  ty: 4};

    localparam logic [4:0] RST_OUT = 5'b11_000;

    logic       clk;
    logic       reset;
    logic [2:0] rgb_def, rgb_scl;
    logic       hsync_def, hsync_scl;
    logic       vsync_def, vsync_scl;
    logic [2:0] exp_color;

    int n_checks = 0;
    int n_errors = 0;

    logic [9:0]  exp_q[$];
    int unsigned since_rst = 0;

    // Glyph art for rows 2..11; every other row of every glyph is blank.
    string art_g [10] = '{"..####..", ".##..##.", "##....#.", "##......", "##......",
                          "##.####.", "##...##.", "##...##.", ".##..##.", "..###.#."};
    string art_r [10] = '{"######..", ".##..##.", ".##..##.", ".##..##.", ".#####..",
                          ".##.##..", ".##..##.", ".##..##.", ".##..##.", "###..##."};
    string art_u [10] = '{"##...##.", "##...##.", "##...##.", "##...##.", "##...##.",
                          "##...##.", "##...##.", "##...##.", "##...##.", ".#####.."};
    string art_p [10] = '{"######..", ".##..##.", ".##..##.", ".##..##.", ".#####..",
                          ".##.....", ".##.....", ".##.....", ".##.....", "####...."};
    string art_o [10] = '{".#####..", "##...##.", "##...##.", "##...##.", "##...##.",
                          "##...##.", "##...##.", "##...##.", "##...##.", ".#####.."};
    string art_1 [10] = '{"...##...", "..###...", ".####...", "...##...", "...##...",
                          "...##...", "...##...", "...##...", "...##...", ".######."};

`ifdef TEXT_COLOR_SW_EN
    logic [2:0] sw;
    assign exp_color = sw;
`else
    assign exp_color = 3'b111;
`endif

    controlador_vga u_dut_def (
        .clk     (clk),
        .reset   (reset),
`ifdef TEXT_COLOR_SW_EN
        .sw      (sw),
`endif
        .rgbtext (rgb_def),
        .hsync   (hsync_def),
        .vsync   (vsync_def)
    );

    controlador_vga #(
        .H_VIS (G_SCL.hv), .H_FP (G_SCL.hf), .H_SP (G_SCL.hs), .H_BP (G_SCL.hb),
        .V_VIS (G_SCL.vv), .V_FP (G_SCL.vf), .V_SP (G_SCL.vs), .V_BP (G_SCL.vb),
        .TXT_X0(G_SCL.tx), .TXT_Y0(G_SCL.ty)
    ) u_dut_scl (
        .clk     (clk),
        .reset   (reset),
`ifdef TEXT_COLOR_SW_EN
        .sw      (sw),
`endif
        .rgbtext (rgb_scl),
        .hsync   (hsync_scl),
        .vsync   (vsync_scl)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic glyph_px(input byte c, input int row, input int col);
        string s;
        s = "........";
        if (row >= 2 && row <= 11) begin
            case (c)
                "G": s = art_g[row-2];
                "R": s = art_r[row-2];
                "U": s = art_u[row-2];
                "P": s = art_p[row-2];
                "O": s = art_o[row-2];
                "1": s = art_1[row-2];
                default: s = "........";
            endcase
        end
        return s[col] == "#";
    endfunction

    // Expected {hsync, vsync, rgb} for pixel-clock position p counted from frame start.
    function automatic logic [4:0] ref_out(input geom_t g, input int unsigned p,
                                           input logic [2:0] color);
        int    ht, vt, h, v, ci;
        logic  hs_n, vs_n, lit;
        string msg;
        msg  = "GRUPO 11";
        ht   = g.hv + g.hf + g.hs + g.hb;
        vt   = g.vv + g.vf + g.vs + g.vb;
        p    = p % (ht * vt);
        h    = p % ht;
        v    = p / ht;
        hs_n = !(h >= g.hv + g.hf && h < g.hv + g.hf + g.hs);
        vs_n = !(v >= g.vv + g.vf && v < g.vv + g.vf + g.vs);
        lit  = 1'b0;
        if (h < g.hv && v < g.vv && h >= g.tx && h < g.tx + 128 &&
            v >= g.ty && v < g.ty + 32) begin
            ci  = (h - g.tx) / 16;
            lit = glyph_px(msg[ci], (v - g.ty) / 2, ((h - g.tx) / 2) % 8);
        end
        return {hs_n, vs_n, lit ? color : 3'b000};
    endfunction

    // Scoreboard: expectation for the outputs produced by this edge.
    // After k edges out of reset the pins show pixel position (k-1)/2.
    always @(posedge clk) begin
        if (reset)
            exp_q.push_back({RST_OUT, RST_OUT});
        else
            exp_q.push_back({ref_out(G_DEF, since_rst / 2, exp_color),
                             ref_out(G_SCL, since_rst / 2, exp_color)});
        since_rst <= reset ? 0 : since_rst + 1;
    end

    always @(negedge clk) begin
        if (exp_q.size() != 0) begin
            check_eq("pix_def", {hsync_def, vsync_def, rgb_def}, {27'd0, exp_q[0][9:5]});
            check_eq("pix_scl", {hsync_scl, vsync_scl, rgb_scl}, {27'd0, exp_q[0][4:0]});
            void'(exp_q.pop_front());
        end
    end

`ifdef TEXT_COLOR_SW_EN
    initial begin
        sw = 3'b100;
        forever begin
            @(negedge clk);
            if ($urandom_range(0, 199) == 0)
                sw = 3'($urandom_range(0, 7));
        end
    end
`endif

    // Count negedges until the selected sync output reaches level (bounded).
    task automatic count_until(input bit sel_v, input logic level, input int budget,
                               output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (((sel_v ? vsync_scl : hsync_def) !== level) && cnt < budget);
    endtask

    task automatic measure_hsync(input string tag);
        int c_fall, c_low, c_high;
        count_until(1'b0, 1'b0, 2000, c_fall);
        check_eq({tag, "_hs_first_fall"}, c_fall, 1313);
        count_until(1'b0, 1'b1, 400, c_low);
        check_eq({tag, "_hs_low_width"}, c_low, 192);
        count_until(1'b0, 1'b0, 2000, c_high);
        check_eq({tag, "_hs_period"}, c_low + c_high, 1600);
    endtask

    initial begin
        int ht_s, vt_s, c_fall, c_low, c_high, target;

        ht_s  = G_SCL.hv + G_SCL.hf + G_SCL.hs + G_SCL.hb;
        vt_s  = G_SCL.vv + G_SCL.vf + G_SCL.vs + G_SCL.vb;

        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("rst_hsync", hsync_def, 1);
        check_eq("rst_vsync", vsync_def, 1);
        check_eq("rst_rgb",   rgb_def,   0);
        reset = 1'b0;

        measure_hsync("init");

        // 2913 edges have elapsed since release inside measure_hsync.
        count_until(1'b1, 1'b0, 20000, c_fall);
        check_eq("vs_first_fall", 2913 + c_fall, 2 * (G_SCL.vv + G_SCL.vf) * ht_s + 1);
        count_until(1'b1, 1'b1, 2000, c_low);
        check_eq("vs_low_width", c_low, 2 * G_SCL.vs * ht_s);
        count_until(1'b1, 1'b0, 20000, c_high);
        check_eq("vs_period", c_low + c_high, 2 * ht_s * vt_s);

        // Reset in the middle of the third frame, around visible line 30.
        target = 2 * (2 * ht_s * vt_s + 30 * ht_s + $urandom_range(0, ht_s - 1)) + 1;
        while (since_rst < target) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_eq("mid_rst_hsync", hsync_scl, 1);
        check_eq("mid_rst_vsync", vsync_scl, 1);
        check_eq("mid_rst_rgb",   rgb_scl,   0);
        reset = 1'b0;
        measure_hsync("mid");

        repeat (4) begin
            repeat ($urandom_range(50, 2000)) @(negedge clk);
            reset = 1'b1;
            repeat ($urandom_range(1, 4)) @(negedge clk);
            reset = 1'b0;
        end
        repeat (2000) @(negedge clk);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2_000_000;
        check_eq("watchdog", 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
